display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_scan_controller_pkg.sv | 19 +
 rtl/display_scan_controller_scan_timebase.sv | 43 ++++
 rtl/display_scan_controller.sv | 121 ++++++++++++
 tb/tb_display_scan_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the display scan controller and its timebase.
package display_scan_controller_pkg;

  // Per-slot phase: BLANK suppresses all digits, ON runs the PWM gate.
  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  localparam logic [3:0] ANODES_OFF = 4'b1111;
  localparam logic [6:0] SEG_BLANK  = 7'b0000000;
  localparam int         SLOT_W     = 26;

  // Active-low one-hot anode pattern for the given digit.
  function automatic logic [3:0] anode_sel(input logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction

endpackage

// File: rtl/display_scan_controller_scan_timebase.sv
// Slot counter, digit index and frame boundary pulse for the scan controller.
module scan_timebase
  import display_scan_controller_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [SLOT_W-1:0] slot_cnt,
  output logic [1:0]        digit_idx,
  output logic              frame_done
);

  localparam logic [SLOT_W-1:0] SLOT_LAST     = SLOT_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_PRE_LAST = SLOT_W'(CLK_DIV - 2);

  logic [SLOT_W-1:0] slot_cnt_reg;
  logic [1:0]        digit_idx_reg;
  logic              frame_done_reg;

  // Count slot cycles, step the digit on wrap; frame_done is registered one
  // cycle early so it is high exactly on digit 3's last slot cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      slot_cnt_reg   <= '0;
      digit_idx_reg  <= 2'd0;
      frame_done_reg <= 1'b0;
    end else begin
      if (slot_cnt_reg == SLOT_LAST) begin
        slot_cnt_reg  <= '0;
        digit_idx_reg <= digit_idx_reg + 2'd1;
      end else begin
        slot_cnt_reg <= slot_cnt_reg + 1'b1;
      end
      frame_done_reg <= (digit_idx_reg == 2'd3) && (slot_cnt_reg == SLOT_PRE_LAST);
    end
  end

  assign slot_cnt   = slot_cnt_reg;
  assign digit_idx  = digit_idx_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed 7-segment scanner with anti-ghost blanking,
// per-slot PWM brightness and frame-synchronous shadow register updates.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [3:0] digit_en,
  input  logic [3:0] brightness,
  input  logic       update_req,
  output logic       update_ack,
  output logic [6:0] segments,
  output logic [3:0] anodes,
  output logic       frame_done
);

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);

  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        digit_idx;
  logic              frame_done_tb;

  scan_timebase #(
    .CLK_DIV(CLK_DIV)
  ) u_timebase (
    .Clock     (Clock),
    .Reset     (Reset),
    .slot_cnt  (slot_cnt),
    .digit_idx (digit_idx),
    .frame_done(frame_done_tb)
  );

  logic [6:0]  shadow_seg_reg [4];
  logic [3:0]  shadow_en_reg;
  logic        update_ack_reg;
  scan_state_t state_reg;
  logic [3:0]  pwm_cnt_reg;
  logic [3:0]  bright_reg;
  logic [3:0]  anodes_reg;
  logic [6:0]  segments_reg;

  logic load;
  logic lit;

  // Shadows only move on the frame boundary so a frame never shows mixed data.
  assign load = frame_done_tb && update_req;
  assign lit  = (state_reg == ON) && shadow_en_reg[digit_idx] && (pwm_cnt_reg <= bright_reg);

  // Handshake: capture the requested pattern on the boundary, ack one cycle later.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shadow_seg_reg[0] <= SEG_BLANK;
      shadow_seg_reg[1] <= SEG_BLANK;
      shadow_seg_reg[2] <= SEG_BLANK;
      shadow_seg_reg[3] <= SEG_BLANK;
      shadow_en_reg     <= 4'b0000;
      update_ack_reg    <= 1'b0;
    end else begin
      update_ack_reg <= load;
      if (load) begin
        shadow_seg_reg[0] <= seg0;
        shadow_seg_reg[1] <= seg1;
        shadow_seg_reg[2] <= seg2;
        shadow_seg_reg[3] <= seg3;
        shadow_en_reg     <= digit_en;
      end
    end
  end

  // Slot FSM with PWM gate; state tracks the current slot cycle and the
  // drive pattern for that cycle is registered out on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg    <= BLANK;
      pwm_cnt_reg  <= 4'd0;
      bright_reg   <= 4'd0;
      anodes_reg   <= ANODES_OFF;
      segments_reg <= SEG_BLANK;
    end else begin
      if (slot_cnt == '0) begin
        bright_reg <= brightness;
      end
      case (state_reg)
        BLANK: begin
          if (slot_cnt == BLANK_LAST) begin
            state_reg   <= ON;
            pwm_cnt_reg <= 4'd0;
          end
        end
        ON: begin
          pwm_cnt_reg <= pwm_cnt_reg + 4'd1;
          if (slot_cnt == SLOT_LAST) begin
            state_reg <= BLANK;
          end
        end
        default: state_reg <= BLANK;
      endcase
      if (lit) begin
        anodes_reg   <= anode_sel(digit_idx);
        segments_reg <= shadow_seg_reg[digit_idx];
      end else begin
        anodes_reg   <= ANODES_OFF;
        segments_reg <= SEG_BLANK;
      end
    end
  end

  assign update_ack = update_ack_reg;
  assign segments   = segments_reg;
  assign anodes     = anodes_reg;
  assign frame_done = frame_done_tb;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with CLK_DIV=40, BLANK_CYCLES=4.
module tb_display_scan_controller;

  localparam int CD = 40;
  localparam int BC = 4;
  localparam int FR = 4 * CD;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [6:0] seg0, seg1, seg2, seg3;
  logic [3:0] digit_en;
  logic [3:0] brightness;
  logic       update_req;
  logic       update_ack;
  logic [6:0] segments;
  logic [3:0] anodes;
  logic       frame_done;

  always #5 Clock = ~Clock;

  display_scan_controller #(
    .CLK_DIV(CD),
    .BLANK_CYCLES(BC)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .seg0      (seg0),
    .seg1      (seg1),
    .seg2      (seg2),
    .seg3      (seg3),
    .digit_en  (digit_en),
    .brightness(brightness),
    .update_req(update_req),
    .update_ack(update_ack),
    .segments  (segments),
    .anodes    (anodes),
    .frame_done(frame_done)
  );

  // g = clock edges since reset release; outputs sampled at g show cycle g-1.
  int         g;
  int         check_cnt;
  int         pass_cnt;
  int         fail_cnt;
  logic [3:0] sh_en;
  logic [6:0] sh_seg [4];
  logic       pend;
  logic [3:0] pend_en;
  logic [6:0] pend_seg [4];
  logic [3:0] slot_b;
  logic       exp_ack;
  int         lit_cnt [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s g=%0d observed=%0h expected=%0h", tag, g, obs, exp);
    end
  endtask

  // One clock; tracks expected shadows/brightness as the spec describes them.
  task automatic tick;
    logic ld;
    ld = !Reset && (g % FR == FR - 1) && update_req;
    if (!Reset && (g % CD == 0)) slot_b = brightness;
    @(posedge Clock);
    if (Reset) begin
      g = 0;
      sh_en = 4'd0;
      for (int i = 0; i < 4; i++) sh_seg[i] = 7'd0;
      pend = 1'b0;
      exp_ack = 1'b0;
    end else begin
      g++;
      if (pend) begin
        sh_en = pend_en;
        for (int i = 0; i < 4; i++) sh_seg[i] = pend_seg[i];
      end
      pend = ld;
      exp_ack = ld;
      if (ld) begin
        pend_en = digit_en;
        pend_seg[0] = seg0; pend_seg[1] = seg1; pend_seg[2] = seg2; pend_seg[3] = seg3;
      end
    end
    @(negedge Clock);
  endtask

  task automatic check_model;
    logic [3:0] ea;
    logic [6:0] es;
    int c, d, p;
    ea = 4'hF;
    es = 7'd0;
    if (g > 0) begin
      c = (g - 1) % CD;
      d = ((g - 1) / CD) % 4;
      if (c >= BC) begin
        p = (c - BC) % 16;
        if (sh_en[d] && p <= int'(slot_b)) begin
          ea = ~(4'b0001 << d);
          es = sh_seg[d];
        end
      end
    end
    check("anodes", 32'(anodes), 32'(ea));
    check("segments", 32'(segments), 32'(es));
    check("frame_done", 32'(frame_done), 32'(g % FR == FR - 1));
    check("update_ack", 32'(update_ack), 32'(exp_ack));
  endtask

  task automatic run_to(input int target);
    while (g < target) begin
      tick();
      check_model();
    end
  endtask

  task automatic count_lit(input int target);
    for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
    while (g < target) begin
      tick();
      check_model();
      if (anodes != 4'hF) lit_cnt[((g - 1) / CD) % 4]++;
    end
  endtask

  initial begin
    g = 0; check_cnt = 0; pass_cnt = 0; fail_cnt = 0;
    pend = 1'b0; exp_ack = 1'b0; sh_en = 4'd0; slot_b = 4'd0;
    for (int i = 0; i < 4; i++) begin sh_seg[i] = 7'd0; pend_seg[i] = 7'd0; end
    pend_en = 4'd0;
    Reset = 1'b1;
    seg0 = 7'd0; seg1 = 7'd0; seg2 = 7'd0; seg3 = 7'd0;
    digit_en = 4'd0; brightness = 4'd15; update_req = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check("rst_anodes", 32'(anodes), 32'h0000000F);
    check("rst_segments", 32'(segments), 32'h0);
    check("rst_ack", 32'(update_ack), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    Reset = 1'b0;

    // Idle scan with empty shadows; first frame boundary at g=159
    run_to(159);
    check("fd_first", 32'(frame_done), 32'h1);
    run_to(330);

    // Request mid-frame; must wait for boundary at g=479, ack at g=480
    seg0 = 7'h3F; seg1 = 7'h06; seg2 = 7'h5B; seg3 = 7'h4F;
    digit_en = 4'hF;
    update_req = 1'b1;
    run_to(480);
    check("ack_pulse", 32'(update_ack), 32'h1);
    update_req = 1'b0;
    run_to(481);
    check("ack_one_cycle", 32'(update_ack), 32'h0);
    run_to(484);
    check("blank_c3", 32'(anodes), 32'h0000000F);
    run_to(485);
    check("d0_anodes", 32'(anodes), 32'h0000000E);
    check("d0_seg", 32'(segments), 32'h0000003F);
    run_to(525);
    check("d1_anodes", 32'(anodes), 32'h0000000D);
    check("d1_seg", 32'(segments), 32'h00000006);
    run_to(565);
    check("d2_anodes", 32'(anodes), 32'h0000000B);
    check("d2_seg", 32'(segments), 32'h0000005B);
    run_to(605);
    check("d3_anodes", 32'(anodes), 32'h00000007);
    check("d3_seg", 32'(segments), 32'h0000004F);
    run_to(640);

    // brightness=3: sampled at g=640 slot start -> 12 lit cycles of 36 ON
    brightness = 4'd3;
    count_lit(680);
    check("pwm3_lit_count", 32'(lit_cnt[0]), 32'd12);
    run_to(685);
    check("pwm3_c4_lit", 32'(anodes), 32'h0000000D);
    run_to(689);
    check("pwm3_c8_dark", 32'(anodes), 32'h0000000F);
    run_to(810);

    // Mid-slot brightness change is ignored until next slot; load en=0101
    brightness = 4'd15;
    digit_en = 4'b0101;
    update_req = 1'b1;
    run_to(960);
    check("ack_en0101", 32'(update_ack), 32'h1);
    update_req = 1'b0;
    count_lit(1120);
    check("lit_d0", 32'(lit_cnt[0]), 32'd36);
    check("lit_d1", 32'(lit_cnt[1]), 32'd0);
    check("lit_d2", 32'(lit_cnt[2]), 32'd36);
    check("lit_d3", 32'(lit_cnt[3]), 32'd0);

    // Pending request aborted by reset in the middle of digit 2
    run_to(1200);
    seg0 = 7'h7F; seg1 = 7'h7F; seg2 = 7'h7F; seg3 = 7'h7F;
    digit_en = 4'hF;
    update_req = 1'b1;
    run_to(1219);
    check("pre_rst_anodes", 32'(anodes), 32'h0000000B);
    check("pre_rst_seg", 32'(segments), 32'h0000005B);
    Reset = 1'b1;
    tick();
    check("mid_rst_anodes", 32'(anodes), 32'h0000000F);
    check("mid_rst_seg", 32'(segments), 32'h0);
    check("mid_rst_ack", 32'(update_ack), 32'h0);
    Reset = 1'b0;
    update_req = 1'b0;
    run_to(159);
    check("fd_after_rst", 32'(frame_done), 32'h1);
    run_to(200);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
